el2_dccm_mem_init: RTL and testbench
====================================

Name: el2_dccm_mem_init

Overview:
- Sits between the core's DCCM bank controls and the DCCM SRAM sink: it drives the sink's inputs and receives the sink's read data.
- After reset, or on request, it walks every DCCM index and writes known data plus matching ECC into all banks in parallel. This prevents spurious ECC errors from uninitialised SRAM.
- While idle or done it is a transparent pass-through of core bank signals. While initialising it owns the SRAM and stalls the core.

Parameters:
- NUM_BANKS, 4, number of DCCM banks (flat bus slices, bank 0 in LSBs).
- ADDR_W, 12, per-bank index width (DCCM_BITS-DCCM_BANK_BITS-2); depth = 2**ADDR_W.
- DATA_W, 32, data bits per bank.
- ECC_W, 7, ECC bits per bank.
- INIT_DATA, 32'h0, data word written to every location.
- INIT_ECC, 7'h0, ECC word written with INIT_DATA (the SECDED code of INIT_DATA).
- AUTO_START, 1, 1 = start initialisation automatically on the first cycle after reset release.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle request to (re)initialise.
- busy_o  out  1  initialisation in progress.
- done_o  out  1  at least one full pass completed since reset; sticky.
- core_stall_o  out  1  core bank request not accepted this cycle.
- core_clken_i  in  NUM_BANKS  core per-bank clock enable.
- core_wren_i  in  NUM_BANKS  core per-bank write enable.
- core_addr_i  in  NUM_BANKS*ADDR_W  core per-bank index.
- core_wr_data_i  in  NUM_BANKS*DATA_W  core write data.
- core_wr_ecc_i  in  NUM_BANKS*ECC_W  core write ECC.
- core_dout_o  out  NUM_BANKS*DATA_W  read data to core.
- core_ecc_o  out  NUM_BANKS*ECC_W  read ECC to core.
- sram_clken_o  out  NUM_BANKS  to SRAM sink.
- sram_wren_o  out  NUM_BANKS  to SRAM sink.
- sram_addr_o  out  NUM_BANKS*ADDR_W  to SRAM sink.
- sram_wr_data_o  out  NUM_BANKS*DATA_W  to SRAM sink.
- sram_wr_ecc_o  out  NUM_BANKS*ECC_W  to SRAM sink.
- sram_dout_i  in  NUM_BANKS*DATA_W  from SRAM sink.
- sram_ecc_i  in  NUM_BANKS*ECC_W  from SRAM sink.

Behaviour:
- Reset state:
  - State = IDLE, cnt = 0, done_o = 0, busy_o = 0.
  - If AUTO_START = 1, a registered pending flag is set on reset. IDLE then goes to INIT on the first clk edge after rst_l deasserts.
- States:
  - IDLE: pass-through. Goes to INIT on start_i or pending.
  - INIT: one index per cycle. Goes to DONE after writing index 2**ADDR_W-1.
  - DONE: pass-through. Goes to INIT on start_i.
- INIT outputs:
  - sram_clken_o and sram_wren_o = all ones.
  - Every bank slice of sram_addr_o = cnt.
  - Data = INIT_DATA, ECC = INIT_ECC, all banks.
  - cnt increments each cycle. On cnt = 2**ADDR_W-1 the next state is DONE, cnt wraps to 0 and done_o is set.
  - Latency from the INIT-entry edge to done_o = 2**ADDR_W cycles.
- Status outputs: busy_o = (state == INIT), registered. core_stall_o = busy_o & |core_clken_i (combinational).
- Core side during INIT:
  - Core requests are not forwarded. The core must hold a stalled request.
  - core_dout_o and core_ecc_o are forced to 0.
- IDLE/DONE: all sram_* = core_* and core_dout_o/core_ecc_o = sram_dout_i/sram_ecc_i, combinational with zero added latency. SRAM read latency is unchanged (1 cycle at the sink).
- start_i while in INIT: ignored; cnt is not restarted.
- start_i in the same cycle as the last index: ignored; state goes to DONE.
- Re-init from DONE: done_o stays 1 while busy_o is 1. The core reads done_o & ~busy_o as "memory valid".
- Reset asserted mid-INIT: immediately returns to the reset state.
  - sram_wren_o follows the core inputs combinationally while in reset.
  - The pass is not resumed; with AUTO_START it restarts from index 0.
- All registers use an asynchronous reset on negedge rst_l. No other clock, and no combinational path from start_i to sram_*.

Test Plan:
- ADDR_W=4, AUTO_START=1, release rst_l -> busy_o=1 on the next edge; 16 consecutive cycles with sram_wren_o=4'hF and addr 0..15 on all banks; then busy_o=0, done_o=1.
- During the above, core_clken_i=4'h1, core_wren_i=0 -> core_stall_o=1 every INIT cycle, sram_addr_o never equals core_addr_i, core_dout_o=0.
- After DONE, core writes bank 2 addr 4'h5 data 32'hDEADBEEF, ecc 7'h2A, then reads it back -> sram_* mirror the core inputs in the same cycle; one cycle later core_dout_o[95:64]=32'hDEADBEEF and core_ecc_o[20:14]=7'h2A.
- AUTO_START=0 -> stays IDLE for 100 cycles (busy_o=0, done_o=0); start_i pulse -> INIT begins on the next edge.
- start_i pulsed at cnt=7 -> ignored; DONE after cnt=15. Second start_i in DONE -> full 16-cycle pass with done_o held at 1.
- rst_l pulled low at cnt=9 -> busy_o=0, done_o=0 immediately; after release (AUTO_START=1) the pass restarts at addr 0.

Source files
------------

// File: rtl/el2_dccm_mem_init.sv
// DCCM initialiser: after reset or on request, writes INIT_DATA/INIT_ECC to every
// index of all banks in parallel; otherwise a transparent pass-through of core bank signals.
module el2_dccm_mem_init #(
  parameter int                NUM_BANKS  = 4,
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 32,
  parameter int                ECC_W      = 7,
  parameter logic [DATA_W-1:0] INIT_DATA  = '0,
  parameter logic [ECC_W-1:0]  INIT_ECC   = '0,
  parameter bit                AUTO_START = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        core_stall_o,
  input  logic [NUM_BANKS-1:0]        core_clken_i,
  input  logic [NUM_BANKS-1:0]        core_wren_i,
  input  logic [NUM_BANKS*ADDR_W-1:0] core_addr_i,
  input  logic [NUM_BANKS*DATA_W-1:0] core_wr_data_i,
  input  logic [NUM_BANKS*ECC_W-1:0]  core_wr_ecc_i,
  output logic [NUM_BANKS*DATA_W-1:0] core_dout_o,
  output logic [NUM_BANKS*ECC_W-1:0]  core_ecc_o,
  output logic [NUM_BANKS-1:0]        sram_clken_o,
  output logic [NUM_BANKS-1:0]        sram_wren_o,
  output logic [NUM_BANKS*ADDR_W-1:0] sram_addr_o,
  output logic [NUM_BANKS*DATA_W-1:0] sram_wr_data_o,
  output logic [NUM_BANKS*ECC_W-1:0]  sram_wr_ecc_o,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout_i,
  input  logic [NUM_BANKS*ECC_W-1:0]  sram_ecc_i
);

  typedef enum logic [1:0] {IDLE, INIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              pending;
  logic              done;
  logic              last_idx;

  assign last_idx = (cnt == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i || pending) state_nxt = INIT;
      INIT:    if (last_idx)           state_nxt = DONE;
      DONE:    if (start_i)            state_nxt = INIT;
      default:                         state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state   <= IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      pending <= AUTO_START;
    end else begin
      state <= state_nxt;
      cnt   <= (state == INIT) ? cnt + 1'b1 : '0;
      if (state == INIT && last_idx) done <= 1'b1;
      if (state_nxt == INIT)         pending <= 1'b0;
    end
  end

  assign busy_o       = (state == INIT);
  assign done_o       = done;
  assign core_stall_o = busy_o & (|core_clken_i);

  // The SRAM mux depends only on registered state, so start_i never reaches sram_*.
  // NOTE: every output is given its pass-through default first; without a default
  // on each path the tool would infer latches.
  always_comb begin
    sram_clken_o   = core_clken_i;
    sram_wren_o    = core_wren_i;
    sram_addr_o    = core_addr_i;
    sram_wr_data_o = core_wr_data_i;
    sram_wr_ecc_o  = core_wr_ecc_i;
    core_dout_o    = sram_dout_i;
    core_ecc_o     = sram_ecc_i;
    if (state == INIT) begin
      sram_clken_o   = '1;
      sram_wren_o    = '1;
      sram_addr_o    = {NUM_BANKS{cnt}};
      sram_wr_data_o = {NUM_BANKS{INIT_DATA}};
      sram_wr_ecc_o  = {NUM_BANKS{INIT_ECC}};
      core_dout_o    = '0;
      core_ecc_o     = '0;
    end
  end

endmodule

// File: tb/tb_el2_dccm_mem_init.sv
// Bench for el2_dccm_mem_init: an auto-start instance on a behavioural SRAM sink and
// a manual-start instance, checked against index-walk and memory reference models.
module tb_el2_dccm_mem_init;

  localparam int NB    = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int EW    = 7;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] INIT_D = 32'h0;
  localparam logic [EW-1:0] INIT_E = 7'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_l, start, rst_b, start_b;
  logic [NB-1:0]    core_clken, core_wren;
  logic [NB*AW-1:0] core_addr;
  logic [NB*DW-1:0] core_wr_data;
  logic [NB*EW-1:0] core_wr_ecc;

  logic             busy, done, core_stall;
  logic [NB*DW-1:0] core_dout, sram_wr_data, sram_dout;
  logic [NB*EW-1:0] core_ecc, sram_wr_ecc, sram_ecc;
  logic [NB-1:0]    sram_clken, sram_wren;
  logic [NB*AW-1:0] sram_addr;

  logic             busy_b, done_b, stall_b;
  logic [NB*DW-1:0] core_dout_b, sram_wr_data_b, sram_dout_b;
  logic [NB*EW-1:0] core_ecc_b, sram_wr_ecc_b, sram_ecc_b;
  logic [NB-1:0]    sram_clken_b, sram_wren_b;
  logic [NB*AW-1:0] sram_addr_b;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  el2_dccm_mem_init #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .ECC_W(EW),
    .INIT_DATA(INIT_D), .INIT_ECC(INIT_E), .AUTO_START(1'b1)) dut (
    .clk(clk), .rst_l(rst_l), .start_i(start), .busy_o(busy), .done_o(done),
    .core_stall_o(core_stall), .core_clken_i(core_clken), .core_wren_i(core_wren),
    .core_addr_i(core_addr), .core_wr_data_i(core_wr_data), .core_wr_ecc_i(core_wr_ecc),
    .core_dout_o(core_dout), .core_ecc_o(core_ecc), .sram_clken_o(sram_clken),
    .sram_wren_o(sram_wren), .sram_addr_o(sram_addr), .sram_wr_data_o(sram_wr_data),
    .sram_wr_ecc_o(sram_wr_ecc), .sram_dout_i(sram_dout), .sram_ecc_i(sram_ecc));

  el2_dccm_mem_init #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .ECC_W(EW),
    .INIT_DATA(INIT_D), .INIT_ECC(INIT_E), .AUTO_START(1'b0)) dut_manual (
    .clk(clk), .rst_l(rst_b), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .core_stall_o(stall_b), .core_clken_i(core_clken), .core_wren_i(core_wren),
    .core_addr_i(core_addr), .core_wr_data_i(core_wr_data), .core_wr_ecc_i(core_wr_ecc),
    .core_dout_o(core_dout_b), .core_ecc_o(core_ecc_b), .sram_clken_o(sram_clken_b),
    .sram_wren_o(sram_wren_b), .sram_addr_o(sram_addr_b), .sram_wr_data_o(sram_wr_data_b),
    .sram_wr_ecc_o(sram_wr_ecc_b), .sram_dout_i(sram_dout_b), .sram_ecc_i(sram_ecc_b));

  // Behavioural SRAM sink with one-cycle read latency.
  logic [DW-1:0] mem_d [NB][DEPTH];
  logic [EW-1:0] mem_e [NB][DEPTH];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (sram_clken[b]) begin
        if (sram_wren[b]) begin
          mem_d[b][sram_addr[b*AW +: AW]] <= sram_wr_data[b*DW +: DW];
          mem_e[b][sram_addr[b*AW +: AW]] <= sram_wr_ecc[b*EW +: EW];
        end else begin
          sram_dout[b*DW +: DW] <= mem_d[b][sram_addr[b*AW +: AW]];
          sram_ecc[b*EW +: EW]  <= mem_e[b][sram_addr[b*AW +: AW]];
        end
      end
    end
  end

  // Reference model of memory contents as the core should see them.
  logic [DW-1:0] ref_d [NB][DEPTH];
  logic [EW-1:0] ref_e [NB][DEPTH];

  task automatic randomize_core();
    core_clken   = NB'($urandom);
    core_wren    = NB'($urandom);
    core_addr    = (NB*AW)'($urandom);
    core_wr_data = {$urandom, $urandom, $urandom, $urandom};
    core_wr_ecc  = (NB*EW)'($urandom);
  endtask

  // Walks one full init pass starting at the next edge; the expected index is simply
  // the number of edges since entry. Optionally pulses start or aborts with reset.
  task automatic walk_pass(input logic done_during, input int start_k1, input int start_k2,
                           input int abort_k);
    logic [AW-1:0] kk;
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1;
      kk = AW'(k);
      core_clken = NB'($urandom) | 4'h1;
      core_wren  = '0;
      for (int b = 0; b < NB; b++) core_addr[b*AW +: AW] = kk ^ AW'($urandom_range(1, 15));
      start = (k == start_k1) || (k == start_k2);
      #1;
      tot_cnt++; if (busy !== 1'b1) $display("FAIL walk_busy k=%0d got=%b exp=1", k, busy); else pass_cnt++;
      tot_cnt++; if (done !== done_during) $display("FAIL walk_done k=%0d got=%b exp=%b", k, done, done_during); else pass_cnt++;
      tot_cnt++; if (core_stall !== 1'b1) $display("FAIL walk_stall k=%0d got=%b exp=1", k, core_stall); else pass_cnt++;
      tot_cnt++; if (sram_wren !== 4'hF || sram_clken !== 4'hF) $display("FAIL walk_wren k=%0d got=%h/%h exp=f/f", k, sram_wren, sram_clken); else pass_cnt++;
      tot_cnt++; if (sram_addr !== {NB{kk}}) $display("FAIL walk_addr k=%0d got=%h exp=%h", k, sram_addr, {NB{kk}}); else pass_cnt++;
      tot_cnt++; if (sram_addr === core_addr) $display("FAIL walk_core_addr_leak k=%0d got=%h", k, sram_addr); else pass_cnt++;
      tot_cnt++; if (sram_wr_data !== {NB{INIT_D}} || sram_wr_ecc !== {NB{INIT_E}}) $display("FAIL walk_wdata k=%0d got=%h/%h exp=0/0", k, sram_wr_data, sram_wr_ecc); else pass_cnt++;
      tot_cnt++; if (core_dout !== '0 || core_ecc !== '0) $display("FAIL walk_core_dout k=%0d got=%h/%h exp=0/0", k, core_dout, core_ecc); else pass_cnt++;
      if (k == abort_k) begin
        rst_l = 1'b0;
        start = 1'b0;
        core_wren = NB'($urandom);
        #1;
        tot_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_status got busy=%b done=%b exp=0/0", busy, done); else pass_cnt++;
        tot_cnt++; if (sram_wren !== core_wren) $display("FAIL abort_wren got=%h exp=%h", sram_wren, core_wren); else pass_cnt++;
        return;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    tot_cnt++; if (busy !== 1'b0 || done !== 1'b1) $display("FAIL pass_end got busy=%b done=%b exp=0/1", busy, done); else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; rst_b = 1'b0; start = 1'b0; start_b = 1'b0;
    randomize_core();
    #1;
    tot_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_status got busy=%b done=%b exp=0/0", busy, done); else pass_cnt++;
    tot_cnt++; if (sram_wren !== core_wren || sram_addr !== core_addr) $display("FAIL reset_passthru got=%h/%h exp=%h/%h", sram_wren, sram_addr, core_wren, core_addr); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    tot_cnt++; if (busy !== 1'b0) $display("FAIL reset_hold_busy got=%b exp=0", busy); else pass_cnt++;
    rst_l = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_auto_init();
    int bad = 0;
    walk_pass(1'b0, -1, -1, -1);
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) begin
        if (mem_d[b][a] !== INIT_D || mem_e[b][a] !== INIT_E) bad++;
        ref_d[b][a] = INIT_D;
        ref_e[b][a] = INIT_E;
      end
    tot_cnt++; if (bad != 0) $display("FAIL init_contents got=%0d bad words exp=0", bad); else pass_cnt++;
  endtask

  task automatic test_core_access();
    core_clken = 4'b0100; core_wren = 4'b0100;
    core_addr = (NB*AW)'($urandom); core_addr[2*AW +: AW] = 4'h5;
    core_wr_data = {$urandom, $urandom, $urandom, $urandom}; core_wr_data[95:64] = 32'hDEADBEEF;
    core_wr_ecc = (NB*EW)'($urandom); core_wr_ecc[20:14] = 7'h2A;
    #1;
    tot_cnt++; if (sram_clken !== core_clken || sram_wren !== core_wren || sram_addr !== core_addr) $display("FAIL mirror_ctl got=%h/%h/%h exp=%h/%h/%h", sram_clken, sram_wren, sram_addr, core_clken, core_wren, core_addr); else pass_cnt++;
    tot_cnt++; if (sram_wr_data !== core_wr_data || sram_wr_ecc !== core_wr_ecc) $display("FAIL mirror_data got=%h/%h exp=%h/%h", sram_wr_data, sram_wr_ecc, core_wr_data, core_wr_ecc); else pass_cnt++;
    tot_cnt++; if (core_stall !== 1'b0) $display("FAIL done_stall got=%b exp=0", core_stall); else pass_cnt++;
    ref_d[2][5] = 32'hDEADBEEF; ref_e[2][5] = 7'h2A;
    @(posedge clk); #1;
    core_wren = '0;
    @(posedge clk); #1;
    core_clken = '0;
    tot_cnt++; if (core_dout[95:64] !== 32'hDEADBEEF || core_ecc[20:14] !== 7'h2A) $display("FAIL readback got=%h/%h exp=deadbeef/2a", core_dout[95:64], core_ecc[20:14]); else pass_cnt++;
    tot_cnt++; if (core_dout !== sram_dout) $display("FAIL dout_passthru got=%h exp=%h", core_dout, sram_dout); else pass_cnt++;
  endtask

  task automatic test_random_traffic();
    logic          exp_v [NB];
    logic [DW-1:0] exp_d [NB];
    logic [EW-1:0] exp_e [NB];
    logic [AW-1:0] a;
    for (int b = 0; b < NB; b++) exp_v[b] = 1'b0;
    for (int t = 0; t <= 60; t++) begin
      @(posedge clk); #1;
      for (int b = 0; b < NB; b++)
        if (exp_v[b]) begin
          tot_cnt++;
          if (core_dout[b*DW +: DW] !== exp_d[b] || core_ecc[b*EW +: EW] !== exp_e[b])
            $display("FAIL rand_read t=%0d bank=%0d got=%h/%h exp=%h/%h", t, b, core_dout[b*DW +: DW], core_ecc[b*EW +: EW], exp_d[b], exp_e[b]);
          else pass_cnt++;
        end
      randomize_core();
      if (t == 60) core_clken = '0;
      for (int b = 0; b < NB; b++) begin
        a = core_addr[b*AW +: AW];
        exp_v[b] = core_clken[b] & ~core_wren[b];
        exp_d[b] = ref_d[b][a];
        exp_e[b] = ref_e[b][a];
        if (core_clken[b] && core_wren[b]) begin
          ref_d[b][a] = core_wr_data[b*DW +: DW];
          ref_e[b][a] = core_wr_ecc[b*EW +: EW];
        end
      end
      #1;
      tot_cnt++; if (core_stall !== 1'b0 || sram_addr !== core_addr || sram_wren !== core_wren) $display("FAIL rand_passthru t=%0d got=%b/%h/%h exp=0/%h/%h", t, core_stall, sram_addr, sram_wren, core_addr, core_wren); else pass_cnt++;
    end
  endtask

  task automatic test_start_in_init();
    start = 1'b1;
    #1;
    tot_cnt++; if (busy !== 1'b0 || sram_wren !== core_wren) $display("FAIL start_comb_path got busy=%b wren=%h exp=0/%h", busy, sram_wren, core_wren); else pass_cnt++;
    walk_pass(1'b1, 7, DEPTH - 1, -1);
    @(posedge clk); #1;
    tot_cnt++; if (busy !== 1'b0 || done !== 1'b1) $display("FAIL last_idx_start got busy=%b done=%b exp=0/1", busy, done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_init();
    start = 1'b1;
    walk_pass(1'b1, -1, -1, 9);
    @(posedge clk); #1;
    tot_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_held got busy=%b done=%b exp=0/0", busy, done); else pass_cnt++;
    rst_l = 1'b1;
    walk_pass(1'b0, -1, -1, -1);
  endtask

  task automatic test_manual_start();
    int bad = 0;
    logic [AW-1:0] kk;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      randomize_core();
      #1;
      if (busy_b !== 1'b0 || done_b !== 1'b0 || sram_wren_b !== core_wren || core_dout_b !== sram_dout_b) bad++;
    end
    tot_cnt++; if (bad != 0) $display("FAIL manual_idle got=%0d bad cycles exp=0", bad); else pass_cnt++;
    start_b = 1'b1;
    #1;
    tot_cnt++; if (busy_b !== 1'b0) $display("FAIL manual_start_comb got=%b exp=0", busy_b); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      kk = AW'(k);
      core_clken = NB'($urandom) | 4'h2;
      #1;
      if (busy_b !== 1'b1 || done_b !== 1'b0 || stall_b !== 1'b1 || sram_clken_b !== 4'hF ||
          sram_wren_b !== 4'hF || sram_addr_b !== {NB{kk}} || sram_wr_data_b !== '0 ||
          sram_wr_ecc_b !== '0 || core_dout_b !== '0 || core_ecc_b !== '0) begin
        bad++;
        $display("FAIL manual_walk k=%0d got busy=%b addr=%h exp busy=1 addr=%h", k, busy_b, sram_addr_b, {NB{kk}});
      end
    end
    tot_cnt++; if (bad != 0) $display("FAIL manual_walk_total got=%0d bad cycles exp=0", bad); else pass_cnt++;
    @(posedge clk); #1;
    tot_cnt++; if (busy_b !== 1'b0 || done_b !== 1'b1) $display("FAIL manual_end got busy=%b done=%b exp=0/1", busy_b, done_b); else pass_cnt++;
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) begin
        mem_d[b][a] = $urandom | 32'h1;
        mem_e[b][a] = EW'($urandom) | 7'h1;
      end
    sram_dout   = {$urandom, $urandom, $urandom, $urandom};
    sram_ecc    = (NB*EW)'($urandom);
    sram_dout_b = {$urandom, $urandom, $urandom, $urandom};
    sram_ecc_b  = (NB*EW)'($urandom);
    test_reset();
    test_auto_init();
    test_core_access();
    test_random_traffic();
    test_start_in_init();
    test_reset_mid_init();
    test_manual_start();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
